// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram
//   NUM_BANKS-deep ring of RAM banks handed between a producer and a consumer.
//   The producer fills the bank at wr_bank and commits it. The consumer reads
//   the bank at rd_bank and releases it. Each bank has a full flag that records
//   which side owns it.
//
// Ports
//   clk, resetn            single clock, async active-low reset
//   wr_en/wr_addr/wr_data  producer write into the current write bank
//   wr_commit              hand the current write bank to the consumer
//   wr_ready, wr_bank      write bank is free / its index
//   rd_en/rd_addr          consumer read of the current read bank
//   rd_release             hand the current read bank back to the producer
//   rd_valid, rd_bank      read bank holds committed data / its index
//   rd_data, rd_data_valid read result, one cycle after an accepted read
//   occupancy              committed, unreleased bank count
//   overflow, underflow    sticky misuse flags
//
// Memory: when SIMULATION_MEMORY is defined, a behavioural array is used.
// Otherwise a dual_port_ram instance is used. A generic dual_port_ram is
// provided below unless DUAL_PORT_RAM_EXTERNAL is defined.
module pingpong_bank_ram #(
  parameter int AWIDTH    = 12,
  parameter int NUM_WORDS = 4096,
  parameter int DWIDTH    = 60,
  parameter int NUM_BANKS = 2,
  parameter int BWIDTH    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  output logic [BWIDTH-1:0] wr_bank,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic              rd_release,
  output logic              rd_valid,
  output logic [BWIDTH-1:0] rd_bank,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [BWIDTH:0]   occupancy,
  output logic              overflow,
  output logic              underflow
);

  logic [NUM_BANKS-1:0]             full;
  logic [BWIDTH-1:0]                wr_bank_q, rd_bank_q, rd_sel_q;
  logic [BWIDTH:0]                  occ_q;
  logic                             rd_vld_q;
  logic [DWIDTH-1:0]                rd_hold;
  logic [NUM_BANKS-1:0][DWIDTH-1:0] ram_q;
  logic                             wr_acc, cm_acc, rd_acc, rl_acc;

  assign wr_ready  = !full[wr_bank_q];
  assign rd_valid  = full[rd_bank_q];
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign occupancy = occ_q;

  assign wr_acc = wr_en      & wr_ready;
  assign cm_acc = wr_commit  & wr_ready;
  assign rd_acc = rd_en      & rd_valid;
  assign rl_acc = rd_release & rd_valid;

  // The RAM output register is not resettable. The result of a read is
  // forwarded in its delivery cycle and then held in rd_hold. This gives
  // rd_data a reset value of 0 and keeps it stable between reads.
  assign rd_data       = rd_vld_q ? ram_q[rd_sel_q] : rd_hold;
  assign rd_data_valid = rd_vld_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full      <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      rd_sel_q  <= '0;
      occ_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_hold   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_sel_q <= rd_bank_q;
      if (rd_vld_q) rd_hold <= ram_q[rd_sel_q];
      // Accepted commit and release never target the same bank. The write
      // side only equals the read side when every bank is full (commit is
      // blocked) or every bank is empty (release is blocked).
      if (cm_acc) begin
        full[wr_bank_q] <= 1'b1;
        wr_bank_q       <= wr_bank_q + 1'b1;
      end
      if (rl_acc) begin
        full[rd_bank_q] <= 1'b0;
        rd_bank_q       <= rd_bank_q + 1'b1;
      end
      case ({cm_acc, rl_acc})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if ((wr_en | wr_commit) & !wr_ready) overflow  <= 1'b1;
      if ((rd_en | rd_release) & !rd_valid) underflow <= 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              we, re;
    logic [DWIDTH-1:0] q;
    assign we = wr_acc & (wr_bank_q == BWIDTH'(b));
    assign re = rd_acc & (rd_bank_q == BWIDTH'(b));
    assign ram_q[b] = q;
`ifdef SIMULATION_MEMORY
    logic [DWIDTH-1:0] mem [NUM_WORDS];
    always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) q <= mem[rd_addr];
    end
`else
    dual_port_ram #(
      .AWIDTH(AWIDTH), .NUM_WORDS(NUM_WORDS), .DWIDTH(DWIDTH)
    ) u_ram (
      .clk     (clk),
      .wr_en   (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (re),
      .rd_addr (rd_addr),
      .rd_data (q)
    );
`endif
  end

endmodule

`ifndef DUAL_PORT_RAM_EXTERNAL
// dual_port_ram
//   Simple dual-port RAM with one write port and one read port. The read
//   data is registered, so it appears one cycle after rd_en.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr/rd_data read port.
module dual_port_ram #(
  parameter int AWIDTH    = 12,
  parameter int NUM_WORDS = 4096,
  parameter int DWIDTH    = 60
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);
  logic [DWIDTH-1:0] mem [NUM_WORDS];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule
`endif
